// File: rtl/systolic_tile_controller.sv
// Sequences a systolic tile job: operand load, fill, result writeback.
// Handles stall back-pressure, abort, and rejection of bad configurations.
module systolic_tile_controller #(
  parameter int ARRAY_SIZE  = 8,
  parameter int K_DEPTH_MAX = 8,
  parameter int IDX_W       = 6,
  parameter int SET_W       = 2,
  parameter int ADDR_W      = 7,
  parameter int CYC_W       = 9
) (
  input  logic              clk,
  input  logic              srstn,
  input  logic              tpu_start,
  input  logic [IDX_W:0]    cfg_k_depth,
  input  logic [SET_W:0]    cfg_num_sets,
  input  logic              stall,
  input  logic              abort,
  output logic              alu_start,
  output logic              sram_write_enable,
  output logic [ADDR_W-1:0] addr_serial_num,
  output logic [CYC_W-1:0]  cycle_num,
  output logic [IDX_W-1:0]  matrix_index,
  output logic [SET_W-1:0]  data_set,
  output logic              busy,
  output logic              tpu_done,
  output logic              aborted,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_ROLL
  } state_t;

  localparam logic [IDX_W:0]    KMAX  = (IDX_W+1)'(K_DEPTH_MAX);
  localparam logic [IDX_W:0]    K_ONE = (IDX_W+1)'(1);
  localparam logic [SET_W:0]    NMAX  = (SET_W+1)'(1 << SET_W);
  localparam logic [SET_W:0]    N_ONE = (SET_W+1)'(1);
  localparam logic [CYC_W-1:0]  FILL  = CYC_W'(ARRAY_SIZE + 1);
  localparam logic [CYC_W-1:0]  C_ONE = CYC_W'(1);
  localparam logic [IDX_W-1:0]  I_ONE = IDX_W'(1);
  localparam logic [SET_W-1:0]  S_ONE = SET_W'(1);
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_TWO = ADDR_W'(2);

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [CYC_W-1:0]    cyc_q;
  logic [IDX_W-1:0]    midx_q;
  logic [SET_W-1:0]    set_q;
  logic [IDX_W:0]      k_q;
  logic [SET_W:0]      n_q;
  logic                done_q;
  logic                abrt_q;
  logic                err_q;

  logic run;
  logic wr;
  logic k_last;
  logic n_last;
  logic cfg_ok;

  // Strobes are forced low while reset is held, even before the first edge.
  assign run    = srstn & (state_q == S_ROLL) & ~stall;
  assign wr     = run & (cyc_q >= FILL);
  assign k_last = ({1'b0, midx_q} == (k_q - K_ONE));
  assign n_last = ({1'b0, set_q} == (n_q - N_ONE));
  assign cfg_ok = (cfg_k_depth != '0) && (cfg_k_depth <= KMAX) &&
                  (cfg_num_sets != '0) && (cfg_num_sets <= NMAX);

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cyc_q   <= '0;
      midx_q  <= '0;
      set_q   <= '0;
      k_q     <= '0;
      n_q     <= '0;
      done_q  <= 1'b0;
      abrt_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      abrt_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort && state_q != S_IDLE) begin
        state_q <= S_IDLE;
        cyc_q   <= '0;
        midx_q  <= '0;
        set_q   <= '0;
        abrt_q  <= 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (tpu_start) begin
              if (cfg_ok) begin
                k_q     <= cfg_k_depth;
                n_q     <= cfg_num_sets;
                addr_q  <= '0;
                state_q <= S_LOAD;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            addr_q  <= A_ONE;
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            addr_q  <= A_TWO;
            cyc_q   <= '0;
            midx_q  <= '0;
            set_q   <= '0;
            state_q <= S_ROLL;
          end
          S_ROLL: begin
            if (!stall) begin
              if (cyc_q != '1) cyc_q <= cyc_q + C_ONE;
              if (addr_q != '1) addr_q <= addr_q + A_ONE;
              if (wr) begin
                if (k_last) begin
                  midx_q <= '0;
                  if (n_last) begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b1;
                    set_q   <= '0;
                    cyc_q   <= '0;
                  end else begin
                    set_q <= set_q + S_ONE;
                  end
                end else begin
                  midx_q <= midx_q + I_ONE;
                end
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign alu_start         = run;
  assign sram_write_enable = wr;
  assign addr_serial_num   = addr_q;
  assign cycle_num         = cyc_q;
  assign matrix_index      = midx_q;
  assign data_set          = set_q;
  assign busy              = srstn & (state_q != S_IDLE);
  assign tpu_done          = done_q;
  assign aborted           = abrt_q;
  assign cfg_err           = err_q;

endmodule

// File: tb/tb_systolic_tile_controller.sv
// Directed bench for systolic_tile_controller.
// Cycle 0 is the cycle whose closing edge samples tpu_start.
module tb_systolic_tile_controller;

  localparam int IDX_W  = 6;
  localparam int SET_W  = 2;
  localparam int ADDR_W = 7;
  localparam int CYC_W  = 9;

  logic              clk;
  logic              srstn;
  logic              tpu_start;
  logic [IDX_W:0]    cfg_k_depth;
  logic [SET_W:0]    cfg_num_sets;
  logic              stall;
  logic              abort;
  logic              alu_start;
  logic              sram_write_enable;
  logic [ADDR_W-1:0] addr_serial_num;
  logic [CYC_W-1:0]  cycle_num;
  logic [IDX_W-1:0]  matrix_index;
  logic [SET_W-1:0]  data_set;
  logic              busy;
  logic              tpu_done;
  logic              aborted;
  logic              cfg_err;

  int n_chk;
  int n_fail;

  systolic_tile_controller dut (
    .clk               (clk),
    .srstn             (srstn),
    .tpu_start         (tpu_start),
    .cfg_k_depth       (cfg_k_depth),
    .cfg_num_sets      (cfg_num_sets),
    .stall             (stall),
    .abort             (abort),
    .alu_start         (alu_start),
    .sram_write_enable (sram_write_enable),
    .addr_serial_num   (addr_serial_num),
    .cycle_num         (cycle_num),
    .matrix_index      (matrix_index),
    .data_set          (data_set),
    .busy              (busy),
    .tpu_done          (tpu_done),
    .aborted           (aborted),
    .cfg_err           (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int k, input int n, input int st_c,
                         input int st_len, input int ab_c, input bit chain,
                         input int exp_done, input string tag);
    int wr;
    bit fin;
    wr  = 0;
    fin = 0;
    cfg_k_depth  = 7'(k);
    cfg_num_sets = 3'(n);
    tpu_start    = 1'b1;
    step();
    tpu_start    = 1'b0;
    cfg_k_depth  = 7'd1;
    cfg_num_sets = 3'd1;
    for (int c = 1; c < 200 && !fin; c++) begin
      stall     = (c >= st_c) && (c < st_c + st_len);
      abort     = (c == ab_c);
      tpu_start = (c == 5);
      #1;
      if (c == 1) check({tag, ":addr_load"}, addr_serial_num, 0);
      if (c == 2) check({tag, ":alu_wait"}, alu_start, 0);
      if (c == 3) check({tag, ":alu_roll"}, alu_start, 1);
      if (c == 3) check({tag, ":addr_roll"}, addr_serial_num, 2);
      if (stall && wr > 0) begin
        check({tag, ":st_alu"}, alu_start, 0);
        check({tag, ":st_we"}, sram_write_enable, 0);
        check({tag, ":st_cyc"}, cycle_num, 9 + wr);
        check({tag, ":st_midx"}, matrix_index, wr % k);
      end
      if (sram_write_enable) begin
        if (wr == 0) check({tag, ":first_wr"}, c, 12);
        check({tag, ":wr_midx"}, matrix_index, wr % k);
        check({tag, ":wr_set"}, data_set, wr / k);
        check({tag, ":wr_cyc"}, cycle_num, 9 + wr);
        wr++;
      end
      step();
      stall     = 1'b0;
      abort     = 1'b0;
      tpu_start = 1'b0;
      if (c == ab_c) begin
        check({tag, ":abort_pulse"}, aborted, 1);
        check({tag, ":abort_busy"}, busy, 0);
        check({tag, ":abort_done"}, tpu_done, 0);
        fin = 1;
      end else if (tpu_done) begin
        check({tag, ":done_cyc"}, c + 1, exp_done);
        check({tag, ":writes"}, wr, k * n);
        check({tag, ":done_busy"}, busy, 0);
        fin = 1;
      end
    end
    if (!fin) check({tag, ":timeout"}, 0, 1);
    if (!chain && ab_c < 0) begin
      step();
      check({tag, ":done_1cyc"}, tpu_done, 0);
      check({tag, ":idle_busy"}, busy, 0);
    end
  endtask

  task automatic bad_cfg(input int k, input int n, input string tag);
    cfg_k_depth  = 7'(k);
    cfg_num_sets = 3'(n);
    tpu_start    = 1'b1;
    step();
    tpu_start = 1'b0;
    check({tag, ":err"}, cfg_err, 1);
    check({tag, ":busy"}, busy, 0);
    step();
    check({tag, ":err_1cyc"}, cfg_err, 0);
    check({tag, ":busy2"}, busy, 0);
  endtask

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    srstn        = 1'b0;
    tpu_start    = 1'b0;
    cfg_k_depth  = '0;
    cfg_num_sets = '0;
    stall        = 1'b0;
    abort        = 1'b0;
    step();
    step();
    check("rst:busy", busy, 0);
    check("rst:cyc", cycle_num, 0);
    check("rst:addr", addr_serial_num, 0);
    check("rst:midx", matrix_index, 0);
    check("rst:done", tpu_done, 0);
    srstn = 1'b1;
    step();

    abort = 1'b1;
    step();
    abort = 1'b0;
    check("idle_abort:pulse", aborted, 0);
    check("idle_abort:busy", busy, 0);

    run_job(8, 1, -1, 0, -1, 0, 20, "k8s1");
    run_job(3, 4, -1, 0, -1, 0, 24, "k3s4");
    run_job(8, 1, 14, 5, -1, 0, 25, "stall");

    run_job(8, 1, -1, 0, 14, 0, 0, "abort");
    check("abort:addr_hold", addr_serial_num, 13);
    check("abort:cyc_clr", cycle_num, 0);
    check("abort:midx_clr", matrix_index, 0);
    run_job(8, 1, -1, 0, -1, 0, 20, "after_abort");

    bad_cfg(0, 1, "k0");
    bad_cfg(9, 1, "k9");
    bad_cfg(4, 5, "n5");

    run_job(2, 1, -1, 0, -1, 1, 14, "chain_a");
    run_job(8, 1, -1, 0, -1, 0, 20, "chain_b");

    cfg_k_depth  = 7'd8;
    cfg_num_sets = 3'd1;
    tpu_start    = 1'b1;
    step();
    tpu_start = 1'b0;
    repeat (9) step();
    srstn = 1'b0;
    #1;
    check("midrst:alu", alu_start, 0);
    check("midrst:we", sram_write_enable, 0);
    check("midrst:busy", busy, 0);
    step();
    check("midrst:cyc", cycle_num, 0);
    check("midrst:addr", addr_serial_num, 0);
    check("midrst:midx", matrix_index, 0);
    check("midrst:set", data_set, 0);
    step();
    srstn = 1'b1;
    step();
    check("postrst:done", tpu_done, 0);
    check("postrst:aborted", aborted, 0);
    check("postrst:busy", busy, 0);
    run_job(8, 1, -1, 0, -1, 0, 20, "postrst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_tile_controller.md
SYSTOLIC_TILE_CONTROLLER -- requirements
Module: systolic_tile_controller

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 8, meaning PE rows/cols; the fill latency is ARRAY_SIZE+1 ROLL cycles.
REQ-002 SHALL have parameter K_DEPTH_MAX, default 8, meaning the maximum runtime accumulation depth.
REQ-003 SHALL have parameter IDX_W, default 6, meaning the matrix_index width; K_DEPTH_MAX SHALL not exceed 2^IDX_W.
REQ-004 SHALL have parameter SET_W, default 2, meaning the data_set width.
REQ-005 SHALL have parameter ADDR_W, default 7, meaning the addr_serial_num width.
REQ-006 SHALL have parameter CYC_W, default 9, meaning the cycle_num width.
REQ-007 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-008 srstn  in  1  reset, synchronous, active-low.
REQ-009 tpu_start  in  1  job start request, sampled in IDLE only.
REQ-010 cfg_k_depth  in  IDX_W+1  accumulation depth; valid range 1..K_DEPTH_MAX; latched at accepted start.
REQ-011 cfg_num_sets  in  SET_W+1  data-set count; valid range 1..2^SET_W; latched at accepted start.
REQ-012 stall  in  1  SRAM back-pressure; freezes the ROLL datapath.
REQ-013 abort  in  1  cancels the job in progress.
REQ-014 alu_start  out  1  shift/MAC enable.
REQ-015 sram_write_enable  out  1  result write strobe.
REQ-016 addr_serial_num  out  ADDR_W  operand read address index.
REQ-017 cycle_num  out  CYC_W  count of ROLL cycles that were not stalled.
REQ-018 matrix_index  out  IDX_W  result row index.
REQ-019 data_set  out  SET_W  current data set.
REQ-020 busy  out  1  high in any non-IDLE state.
REQ-021 tpu_done  out  1  one-cycle completion pulse.
REQ-022 aborted  out  1  one-cycle abort acknowledge pulse.
REQ-023 cfg_err  out  1  one-cycle invalid-configuration pulse.

Function
REQ-024 SHALL implement the states IDLE, LOAD, WAIT, ROLL; busy SHALL equal (state != IDLE).
REQ-025 In IDLE with tpu_start=1 and a valid configuration, the block SHALL latch cfg_k_depth and cfg_num_sets, set addr=0, and go to LOAD.
REQ-026 In IDLE with tpu_start=1 and an invalid configuration (zero, or above the maximum), the block SHALL stay in IDLE and pulse cfg_err the next cycle.
REQ-027 LOAD SHALL go to WAIT with addr<=1; WAIT SHALL go to ROLL with addr<=2; cycle_num, matrix_index and data_set SHALL be 0 on entry to ROLL.
REQ-028 In ROLL with stall=0: alu_start=1, cycle_num increments and saturates at all-ones, and addr increments and saturates at all-ones.
REQ-029 In ROLL with stall=0 and cycle_num >= ARRAY_SIZE+1: sram_write_enable=1, and matrix_index increments.
REQ-030 When matrix_index reaches k_depth-1 under REQ-029, it SHALL wrap to 0 and data_set SHALL increment.
REQ-031 While cycle_num < ARRAY_SIZE+1, matrix_index and data_set SHALL hold and sram_write_enable SHALL be 0.
REQ-032 Termination: when a write occurs with matrix_index==k_depth-1 and data_set==num_sets-1, the next state SHALL be IDLE and tpu_done SHALL be registered high for exactly 1 cycle.
REQ-033 In ROLL with stall=1: alu_start=0 and sram_write_enable=0, all counters and addr SHALL hold, and termination SHALL be deferred.
REQ-034 alu_start and sram_write_enable SHALL be combinational from state, stall and cycle_num; they SHALL be 0 outside ROLL.
REQ-035 abort=1 in a non-IDLE state SHALL force IDLE on the next edge and clear cycle_num, matrix_index and data_set; addr SHALL hold.
REQ-036 After REQ-035, aborted SHALL pulse for 1 cycle and tpu_done SHALL not assert.
REQ-037 abort SHALL take priority over termination and over stall.
REQ-038 abort in IDLE SHALL have no effect.
REQ-039 tpu_start while busy SHALL be ignored; the latched configuration SHALL not change during a job.
REQ-040 Changes on cfg_k_depth or cfg_num_sets after the accepted start SHALL have no effect on the running job.
REQ-041 The same-cycle IDLE restart after tpu_done SHALL be legal: start is accepted in the first IDLE cycle.

Reset
REQ-042 srstn=0 SHALL set state=IDLE and clear cycle_num, matrix_index, data_set, addr, the latched configuration, tpu_done, aborted and cfg_err to 0.
REQ-043 During reset, alu_start, sram_write_enable and busy SHALL be 0.
REQ-044 Reset mid-ROLL SHALL abandon the job with no tpu_done and no aborted pulse.

Verification
REQ-045 Defaults, k=8, sets=1, start pulse at cycle 0 -> ROLL from cycle 3; sram_write_enable high for 8 consecutive cycles with cycle_num 9..16 and matrix_index 0..7; tpu_done 1 cycle after the last write.
REQ-046 k=3, sets=4 -> 12 writes; matrix_index sequence 0,1,2 repeated; data_set 0..3; single tpu_done.
REQ-047 Stall held 5 cycles mid-write -> outputs frozen and no writes during the stall; total write count unchanged; tpu_done delayed by exactly 5 cycles.
REQ-048 Abort at the 3rd write -> aborted pulse, busy=0 next cycle, no tpu_done; an immediate restart completes normally.
REQ-049 cfg_k_depth=0 or cfg_k_depth=9 with start -> cfg_err pulse; busy stays 0.
REQ-050 srstn=0 mid-ROLL, then a clean job -> all outputs 0 during reset; the following job matches REQ-045.
